fisr_iter: RTL and testbench



---
 rtl/fisr_pkg.sv | 22 ++
 rtl/fp32_mul_trunc.sv | 21 ++
 rtl/fisr_iter.sv | 109 ++++++++++
 tb/tb_fisr_iter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fisr_pkg.sv
// fisr_pkg: shared constants, FSM states and fp32 field helpers for fisr_iter
package fisr_pkg;
    localparam logic [31:0] MAGIC_DEFAULT  = 32'h5f3759df;
    localparam logic [31:0] FP32_CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] FP32_POS_INF   = 32'h7F800000;
    localparam logic [31:0] FP32_ZERO      = 32'h00000000;
    localparam logic [31:0] THREEHALFS_Q   = 32'h60000000;

    typedef enum logic [2:0] {IDLE, SEED, SQ, MXY, SUB, UPD, DONE} state_t;

    function automatic logic fp_sign(input logic [31:0] v);
        return v[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] v);
        return v[30:23];
    endfunction

    function automatic logic [22:0] fp_mant(input logic [31:0] v);
        return v[22:0];
    endfunction
endpackage

// File: rtl/fp32_mul_trunc.sv
// fp32_mul_trunc: combinational fp32 multiply, truncating, denormals flushed to +0, overflow to +inf
module fp32_mul_trunc
    import fisr_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    logic [47:0] prod;
    logic [9:0]  e;
    logic [22:0] m;

    always_comb begin
        prod = {1'b1, fp_mant(a)} * {1'b1, fp_mant(b)};
        e    = {2'b0, fp_exp(a)} + {2'b0, fp_exp(b)} + {9'b0, prod[47]} - 10'd127;
        m    = 23'(prod >> (6'd23 + {5'd0, prod[47]}));
        p    = (fp_exp(a) == 8'd0 || fp_exp(b) == 8'd0 || e[9] || e == 10'd0) ? FP32_ZERO
             : (e >= 10'd255) ? FP32_POS_INF
             : {fp_sign(a) ^ fp_sign(b), e[7:0], m};
    end
endmodule

// File: rtl/fisr_iter.sv
// fisr_iter: fp32 1/sqrt(x) from a magic seed plus NR_ITER Newton steps on one shared multiplier.
// Defining FISR_STATUS_EN adds out_flags = {nan_or_neg, zero_or_denorm, pos_inf}.
module fisr_iter
    import fisr_pkg::*;
#(
    parameter int          NR_ITER = 1,
    parameter logic [31:0] MAGIC   = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] DataIn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] DataOut
`ifdef FISR_STATUS_EN
    ,
    output logic [2:0]  out_flags
`endif
);
    state_t      state, nxt;
    logic [31:0] x, y, t, ma, mb, mp, th, tq, d, rf, spec_val;
    logic [1:0]  cnt;
    logic [4:0]  lz;
    logic        accept, last, nan_or_neg, zero_den, pos_inf;

    fp32_mul_trunc u_mul (.a(ma), .b(mb), .p(mp));

    always_comb begin
        nan_or_neg = (fp_sign(DataIn) && DataIn[30:0] != 31'd0)
                   || (fp_exp(DataIn) == 8'hFF && fp_mant(DataIn) != 23'd0);
        zero_den   = !nan_or_neg && fp_exp(DataIn) == 8'd0;
        pos_inf    = DataIn == FP32_POS_INF;
        spec_val   = nan_or_neg ? FP32_CANON_NAN : zero_den ? FP32_POS_INF : FP32_ZERO;
        in_ready   = state == IDLE;
        accept     = in_valid && in_ready;
        last       = cnt + 2'd1 == 2'(NR_ITER);
        ma         = state == MXY ? x : y;
        mb         = state == SQ ? y : t;
        th         = fp_exp(mp) <= 8'd1 ? FP32_ZERO : mp - 32'h0080_0000;
        // t as unsigned Q2.30: value = 1.m * 2^(e-127), so shift {1,m} by e-120
        tq         = fp_exp(t) >= 8'd128 ? 32'h7FFF_FFFF
                   : fp_exp(t) == 8'd0 ? 32'd0
                   : fp_exp(t) >= 8'd120 ? {8'd0, 1'b1, fp_mant(t)} << (fp_exp(t) - 8'd120)
                   : {8'd0, 1'b1, fp_mant(t)} >> (8'd120 - fp_exp(t));
        d          = THREEHALFS_Q - tq;
        lz         = 5'd0;
        for (int i = 0; i < 31; i++)
            if (d[i]) lz = 5'(i);
        rf         = tq >= THREEHALFS_Q ? FP32_ZERO
                   : {1'b0, 8'd97 + {3'd0, lz}, 23'({d, 23'd0} >> lz)};
        nxt        = state == IDLE ? (accept ? ((nan_or_neg || zero_den || pos_inf) ? DONE : SEED) : IDLE)
                   : state == SEED ? (NR_ITER == 0 ? DONE : SQ)
                   : state == SQ   ? MXY
                   : state == MXY  ? SUB
                   : state == SUB  ? UPD
                   : state == UPD  ? (last ? DONE : SQ)
                   : (out_valid && out_ready) ? IDLE : DONE;
    end

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            t         <= '0;
            cnt       <= '0;
            DataOut   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                x   <= DataIn;
                y   <= spec_val;
                cnt <= '0;
            end
            if (state == SEED) y <= MAGIC - (x >> 1);
            if (state == SQ)   t <= mp;
            if (state == MXY)  t <= th;
            if (state == SUB)  t <= rf;
            if (state == UPD) begin
                y   <= mp;
                cnt <= cnt + 2'd1;
            end
            // first DONE cycle publishes y; it then holds until the consumer takes it
            if (state == DONE) begin
                out_valid <= !(out_valid && out_ready);
                if (!out_valid) DataOut <= y;
            end
        end
    end

`ifdef FISR_STATUS_EN
    logic [2:0] flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags     <= '0;
            out_flags <= '0;
        end else begin
            if (accept) flags <= {nan_or_neg, zero_den, pos_inf};
            if (state == DONE && !out_valid) out_flags <= flags;
        end
    end
`endif
endmodule

// File: tb/tb_fisr_iter.sv
// tb_fisr_iter: randomized self-checking bench for fisr_iter, one instance per NR_ITER 0..3
`timescale 1ns/1ps
module tb_fisr_iter;
    localparam logic [31:0] MAGIC = 32'h5f3759df;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv [4];
    logic        ir [4];
    logic        ov [4];
    logic        ordy [4];
    logic [31:0] din [4];
    logic [31:0] dout [4];
`ifdef FISR_STATUS_EN
    logic [2:0]  flags_w [4];
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fisr_iter #(.NR_ITER(g)) dut (
            .clk(clk), .rst(rst),
            .in_valid(iv[g]), .in_ready(ir[g]), .DataIn(din[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]), .DataOut(dout[g])
`ifdef FISR_STATUS_EN
            , .out_flags(flags_w[g])
`endif
        );
    end

    function automatic real f2r(input logic [31:0] b);
        logic [63:0] v;
        if (b[30:23] == 8'd0) return 0.0;
        v = {b[31], {3'b0, b[30:23]} + 11'd896, b[22:0], 29'b0};
        return $bitstoreal(v);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] v;
        v = $realtobits(r);
        return {v[63], 8'(v[62:52] - 11'd896), v[51:29]};
    endfunction

    function automatic bit is_special(input logic [31:0] v);
        return (v[31] && v[30:0] != 31'd0) || v[30:23] == 8'hFF || v[30:23] == 8'd0;
    endfunction

    function automatic logic [31:0] special_val(input logic [31:0] v);
        if ((v[30:23] == 8'hFF && v[22:0] != 23'd0) || (v[31] && v[30:0] != 31'd0)) return 32'h7FC00000;
        if (v[30:23] == 8'd0) return 32'h7F800000;
        return 32'h00000000;
    endfunction

    function automatic real tol_of(input int k);
        return k == 1 ? 2.5e-3 : k == 2 ? 1.0e-5 : 2.0e-6;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp, input real tol = 0.0);
        bit ok;
        real g, e;
        total++;
        g = f2r(got);
        e = f2r(exp);
        ok = tol == 0.0 ? got === exp : (g - e <= tol * e && e - g <= tol * e);
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xact(input int k, input logic [31:0] v, output logic [31:0] res, output int lat);
        int n;
        @(negedge clk);
        din[k] = v;
        iv[k] = 1'b1;
        n = 0;
        while (!ir[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        res = dout[k];
        ordy[k] = 1'b1;
        @(posedge clk);
        #1 ordy[k] = 1'b0;
    endtask

    task automatic run(input int k, input logic [31:0] v);
        logic [31:0] res;
        int lat;
        xact(k, v, res, lat);
        if (is_special(v)) begin
            chk("spec_lat", 32'(lat), 32'd1);
            chk("spec_val", res, special_val(v));
        end else begin
            chk($sformatf("lat_nr%0d", k), 32'(lat), 32'(2 + 4 * k));
            if (k == 0) chk("seed", res, MAGIC - (v >> 1));
            else chk($sformatf("val_nr%0d", k), res, r2f(1.0 / $sqrt(f2r(v))), tol_of(k));
        end
    endtask

    initial begin
        logic [31:0] res, held, v;
        int lat, n, k;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b0;
            din[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_ov", 32'(ov[i]), 32'd0);
            chk("rst_do", dout[i], 32'd0);
            chk("rst_ir", 32'(ir[i]), 32'd1);
        end
        rst = 1'b0;

        xact(0, 32'h40800000, res, lat);
        chk("nr0_lat", 32'(lat), 32'd2);
        chk("nr0_val", res, 32'h3EF759DF);
        xact(1, 32'h40800000, res, lat);
        chk("nr1_lat", 32'(lat), 32'd6);
        chk("nr1_val", res, 32'h3F000000, 0.002);
        xact(2, 32'h3F800000, res, lat);
        chk("nr2_lat", 32'(lat), 32'd10);
        chk("nr2_val", res, 32'h3F800000, 5.0e-6);
        run(1, 32'hBF800000);
        run(1, 32'h00000000);
        run(1, 32'h7F800000);

        // back-pressure in DONE with a new operand already waiting
        @(negedge clk);
        din[1] = 32'h40800000;
        iv[1] = 1'b1;
        @(posedge clk);
        #1 din[1] = 32'h3F800000;
        n = 0;
        while (!ov[1] && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("hold_lat", 32'(n), 32'd6);
        held = dout[1];
        chk("hold_val", held, 32'h3F000000, 0.002);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_ov", 32'(ov[1]), 32'd1);
            chk("hold_do", dout[1], held);
            chk("hold_ir", 32'(ir[1]), 32'd0);
        end
        ordy[1] = 1'b1;
        @(posedge clk);
        #1 ordy[1] = 1'b0;
        chk("turn_ov", 32'(ov[1]), 32'd0);
        chk("turn_ir", 32'(ir[1]), 32'd1);
        @(posedge clk);
        #1 iv[1] = 1'b0;
        n = 0;
        while (!ov[1] && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("turn_lat", 32'(n), 32'd6);
        chk("turn_val", dout[1], r2f(1.0), tol_of(1));
        ordy[1] = 1'b1;
        @(posedge clk);
        #1 ordy[1] = 1'b0;

        // reset while the operand sits in SQ
        @(negedge clk);
        din[1] = 32'h40800000;
        iv[1] = 1'b1;
        @(posedge clk);
        #1 iv[1] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_ov", 32'(ov[1]), 32'd0);
        chk("abort_do", dout[1], 32'd0);
        chk("abort_ir", 32'(ir[1]), 32'd1);
        n = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (ov[1]) n++;
        end
        chk("abort_quiet", 32'(n), 32'd0);
        run(1, 32'h40800000);

        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: v = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
                    1: v = {1'b0, 8'hFF, 23'($urandom) | 23'd1};
                    2: v = {1'($urandom), 8'h00, 23'($urandom)};
                    3: v = 32'h7F800000;
                    default: v = 32'hFF800000;
                endcase
            end else begin
                v = {1'b0, 8'($urandom_range(64, 190)), 23'($urandom)};
            end
            run(k, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
